// File: rtl/whack_judge_if.sv
// ============================================================================
// Module   : whack_judge_if
// Purpose  : Keypad, mole and score signals between the game logic and the judge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface whack_judge_if #(
  parameter int SCORE_W = 8
);
  logic [3:0]         Rows;
  logic [1:0]         decoded_row;
  logic [1:0]         decoded_col;
  logic               mole_valid;
  logic [1:0]         mole_row;
  logic [1:0]         mole_col;
  logic               clear_score;
  logic               key_event;
  logic [1:0]         key_row;
  logic [1:0]         key_col;
  logic               hit;
  logic               miss;
  logic [SCORE_W-1:0] score;
  logic [3:0]         combo;

  modport master (
    output Rows, decoded_row, decoded_col, mole_valid, mole_row, mole_col,
           clear_score,
    input  key_event, key_row, key_col, hit, miss, score, combo
  );

  modport slave (
    input  Rows, decoded_row, decoded_col, mole_valid, mole_row, mole_col,
           clear_score,
    output key_event, key_row, key_col, hit, miss, score, combo
  );
endinterface

`default_nettype wire

// File: rtl/whack_judge.sv
// ============================================================================
// Module   : whack_judge
// Purpose  : Debounces one keypad press per release and scores it against the
//            mole; optional macro WHACK_MISS_PENALTY_EN makes a miss cost a point.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module whack_judge #(
  parameter int SCAN_WINDOW = 400000,
  parameter int SCORE_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  whack_judge_if.slave     bus_if
);

  localparam int                 CNT_W     = $clog2(SCAN_WINDOW);
  localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(SCAN_WINDOW - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [3:0]         COMBO_MAX = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_JUDGE  = 2'd2,
    S_HELD   = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         rows_meta_q;
  logic [3:0]         rows_sync_q;
  logic               key_event_q;
  logic               hit_q;
  logic               miss_q;
  logic [1:0]         key_row_q;
  logic [1:0]         key_col_q;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_d;
  logic [3:0]         combo_q;
  logic [3:0]         combo_d;
  logic               active_w;
  logic               match_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_meta_q <= 4'hF;
      rows_sync_q <= 4'hF;
    end else begin
      rows_meta_q <= bus_if.Rows;
      rows_sync_q <= rows_meta_q;
    end
  end

  assign active_w = (rows_sync_q != 4'hF);
  assign match_w  = bus_if.mole_valid &&
                    (bus_if.decoded_row == bus_if.mole_row) &&
                    (bus_if.decoded_col == bus_if.mole_col);

  // One counter serves both the settle delay and the release (quiet) timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      key_event_q <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      key_row_q   <= 2'd0;
      key_col_q   <= 2'd0;
    end else begin
      key_event_q <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (active_w) begin
            state_q <= S_SETTLE;
            cnt_q   <= '0;
          end
        end
        S_SETTLE: begin
          if (cnt_q == LAST_CNT) begin
            state_q <= S_JUDGE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_JUDGE: begin
          key_row_q   <= bus_if.decoded_row;
          key_col_q   <= bus_if.decoded_col;
          key_event_q <= 1'b1;
          hit_q       <= match_w;
          miss_q      <= !match_w;
          state_q     <= S_HELD;
          cnt_q       <= '0;
        end
        S_HELD: begin
          if (active_w) begin
            cnt_q <= '0;
          end else if (cnt_q == LAST_CNT) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Scoring acts on the registered verdict, so clear_score in the pulse
  // cycle wins over that verdict.
  always_comb begin
    score_d = score_q;
    combo_d = combo_q;
    if (bus_if.clear_score) begin
      score_d = '0;
      combo_d = 4'd0;
    end else if (hit_q) begin
      if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
      if (combo_q != COMBO_MAX) combo_d = combo_q + 1'b1;
    end else if (miss_q) begin
      combo_d = 4'd0;
`ifdef WHACK_MISS_PENALTY_EN
      if (score_q != '0) score_d = score_q - 1'b1;
`else
      score_d = score_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q <= '0;
      combo_q <= 4'd0;
    end else begin
      score_q <= score_d;
      combo_q <= combo_d;
    end
  end

  assign bus_if.key_event = key_event_q;
  assign bus_if.hit       = hit_q;
  assign bus_if.miss      = miss_q;
  assign bus_if.key_row   = key_row_q;
  assign bus_if.key_col   = key_col_q;
  assign bus_if.score     = score_q;
  assign bus_if.combo     = combo_q;

endmodule

`default_nettype wire

// File: tb/tb_whack_judge.sv
// ============================================================================
// Module   : tb_whack_judge
// Purpose  : Directed self-checking bench for whack_judge (SCAN_WINDOW=16, SCORE_W=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_whack_judge;

  localparam int SW = 16;
`ifdef WHACK_MISS_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  whack_judge_if #(.SCORE_W(4)) bus ();

  whack_judge #(.SCAN_WINDOW(SW), .SCORE_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  int errors = 0;
  int checks = 0;
  int ev_cnt = 0;
  int hit_cnt = 0;
  int miss_cnt = 0;

  always @(negedge clk) begin
    if (bus.key_event === 1'b1) ev_cnt++;
    if (bus.hit === 1'b1) hit_cnt++;
    if (bus.miss === 1'b1) miss_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_keys(input logic mv, input logic [1:0] mr, input logic [1:0] mc,
                          input logic [1:0] dr, input logic [1:0] dc);
    bus.mole_valid  = mv;
    bus.mole_row    = mr;
    bus.mole_col    = mc;
    bus.decoded_row = dr;
    bus.decoded_col = dc;
  endtask

  task automatic press(input int hold);
    bus.Rows = 4'b1011;
    tick(hold);
    bus.Rows = 4'hF;
    tick(30);
  endtask

  task automatic do_clear();
    bus.clear_score = 1'b1;
    tick(1);
    bus.clear_score = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++;
    if ({bus.key_event, bus.hit, bus.miss} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses: got %b expected 000", {bus.key_event, bus.hit, bus.miss});
    end
    checks++;
    if ({bus.key_row, bus.key_col, bus.score, bus.combo} !== 12'h000) begin
      errors++;
      $display("FAIL reset_regs: got %h expected 000", {bus.key_row, bus.key_col, bus.score, bus.combo});
    end
    rst_n = 1'b1;
    tick(5);
    checks++;
    if (ev_cnt !== 0) begin
      errors++;
      $display("FAIL reset_no_event: got %0d expected 0", ev_cnt);
    end
  endtask

  task automatic test_hit();
    int e0, h0, m0;
    e0 = ev_cnt; h0 = hit_cnt; m0 = miss_cnt;
    set_keys(1'b1, 2'd1, 2'd2, 2'd1, 2'd2);
    bus.Rows = 4'b1011;
    tick(SW + 3);
    checks++;
    if (bus.key_event !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got %b expected 0", bus.key_event);
    end
    tick(1);
    checks++;
    if ({bus.key_event, bus.hit, bus.miss} !== 3'b110) begin
      errors++;
      $display("FAIL latency_pulse: got %b expected 110", {bus.key_event, bus.hit, bus.miss});
    end
    tick(1);
    checks++;
    if ({bus.key_event, bus.hit} !== 2'b00) begin
      errors++;
      $display("FAIL pulse_width: got %b expected 00", {bus.key_event, bus.hit});
    end
    tick(40 - SW - 5);
    bus.Rows = 4'hF;
    tick(30);
    checks++;
    if ((ev_cnt - e0) !== 1 || (hit_cnt - h0) !== 1 || (miss_cnt - m0) !== 0) begin
      errors++;
      $display("FAIL hit_counts: got ev=%0d hit=%0d miss=%0d expected 1 1 0",
               ev_cnt - e0, hit_cnt - h0, miss_cnt - m0);
    end
    checks++;
    if (bus.score !== 4'd1 || bus.combo !== 4'd1) begin
      errors++;
      $display("FAIL hit_score: got score=%0d combo=%0d expected 1 1", bus.score, bus.combo);
    end
    checks++;
    if (bus.key_row !== 2'd1 || bus.key_col !== 2'd2) begin
      errors++;
      $display("FAIL hit_key: got row=%0d col=%0d expected 1 2", bus.key_row, bus.key_col);
    end
  endtask

  task automatic test_miss();
    int h0, m0;
    logic [3:0] exp_score;
    repeat (4) press(24);
    checks++;
    if (bus.score !== 4'd5 || bus.combo !== 4'd5) begin
      errors++;
      $display("FAIL pre_miss_score: got score=%0d combo=%0d expected 5 5", bus.score, bus.combo);
    end
    set_keys(1'b1, 2'd0, 2'd0, 2'd3, 2'd3);
    h0 = hit_cnt; m0 = miss_cnt;
    press(24);
    exp_score = PEN ? 4'd4 : 4'd5;
    checks++;
    if ((miss_cnt - m0) !== 1 || (hit_cnt - h0) !== 0) begin
      errors++;
      $display("FAIL miss_counts: got miss=%0d hit=%0d expected 1 0", miss_cnt - m0, hit_cnt - h0);
    end
    checks++;
    if (bus.score !== exp_score || bus.combo !== 4'd0) begin
      errors++;
      $display("FAIL miss_score: got score=%0d combo=%0d expected %0d 0", bus.score, bus.combo, exp_score);
    end
    do_clear();
    press(24);
    checks++;
    if (bus.score !== 4'd0 || bus.combo !== 4'd0) begin
      errors++;
      $display("FAIL miss_floor: got score=%0d combo=%0d expected 0 0", bus.score, bus.combo);
    end
  endtask

  task automatic test_held();
    int e0;
    e0 = ev_cnt;
    bus.Rows = 4'b1110;
    tick(500);
    checks++;
    if ((ev_cnt - e0) !== 1) begin
      errors++;
      $display("FAIL held_single: got %0d expected 1", ev_cnt - e0);
    end
    bus.Rows = 4'hF;
    tick(SW - 1);
    bus.Rows = 4'b1110;
    tick(40);
    checks++;
    if ((ev_cnt - e0) !== 1) begin
      errors++;
      $display("FAIL held_short_quiet: got %0d expected 1", ev_cnt - e0);
    end
    bus.Rows = 4'hF;
    tick(SW);
    bus.Rows = 4'b1110;
    tick(40);
    checks++;
    if ((ev_cnt - e0) !== 2) begin
      errors++;
      $display("FAIL held_full_quiet: got %0d expected 2", ev_cnt - e0);
    end
    bus.Rows = 4'hF;
    tick(30);
  endtask

  task automatic test_invalid_mole();
    int h0, m0;
    set_keys(1'b0, 2'd1, 2'd2, 2'd1, 2'd2);
    h0 = hit_cnt; m0 = miss_cnt;
    press(24);
    checks++;
    if ((miss_cnt - m0) !== 1 || (hit_cnt - h0) !== 0) begin
      errors++;
      $display("FAIL invalid_mole: got miss=%0d hit=%0d expected 1 0", miss_cnt - m0, hit_cnt - h0);
    end
  endtask

  task automatic test_saturation();
    int h0;
    do_clear();
    set_keys(1'b1, 2'd2, 2'd3, 2'd2, 2'd3);
    h0 = hit_cnt;
    repeat (20) press(24);
    checks++;
    if ((hit_cnt - h0) !== 20) begin
      errors++;
      $display("FAIL sat_hits: got %0d expected 20", hit_cnt - h0);
    end
    checks++;
    if (bus.score !== 4'd15 || bus.combo !== 4'd15) begin
      errors++;
      $display("FAIL sat_score: got score=%0d combo=%0d expected 15 15", bus.score, bus.combo);
    end
  endtask

  task automatic test_clear_on_hit();
    bit found;
    found = 1'b0;
    bus.Rows = 4'b0111;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(1);
      if (bus.key_event === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL clear_wait: got no key_event expected one within 60 cycles");
    end else begin
      checks++;
      if (bus.hit !== 1'b1) begin
        errors++;
        $display("FAIL clear_hit_pulse: got %b expected 1", bus.hit);
      end
      bus.clear_score = 1'b1;
      tick(1);
      bus.clear_score = 1'b0;
      checks++;
      if (bus.score !== 4'd0 || bus.combo !== 4'd0) begin
        errors++;
        $display("FAIL clear_on_hit: got score=%0d combo=%0d expected 0 0", bus.score, bus.combo);
      end
    end
    bus.Rows = 4'hF;
    tick(30);
  endtask

  task automatic test_reset_mid_settle();
    int e0;
    set_keys(1'b1, 2'd3, 2'd1, 2'd3, 2'd1);
    e0 = ev_cnt;
    bus.Rows = 4'b1101;
    tick(8);
    rst_n = 1'b0;
    tick(2);
    checks++;
    if ((ev_cnt - e0) !== 0) begin
      errors++;
      $display("FAIL rst_abort_event: got %0d expected 0", ev_cnt - e0);
    end
    checks++;
    if ({bus.key_event, bus.hit, bus.miss, bus.key_row, bus.key_col, bus.score, bus.combo} !== 15'd0) begin
      errors++;
      $display("FAIL rst_abort_outputs: got %h expected 0",
               {bus.key_event, bus.hit, bus.miss, bus.key_row, bus.key_col, bus.score, bus.combo});
    end
    rst_n = 1'b1;
    tick(SW + 3);
    checks++;
    if (bus.key_event !== 1'b0) begin
      errors++;
      $display("FAIL rst_repress_early: got %b expected 0", bus.key_event);
    end
    tick(1);
    checks++;
    if ({bus.key_event, bus.hit, bus.key_row, bus.key_col} !== 6'b11_11_01) begin
      errors++;
      $display("FAIL rst_repress_event: got %b expected 111101",
               {bus.key_event, bus.hit, bus.key_row, bus.key_col});
    end
    bus.Rows = 4'hF;
    tick(30);
    checks++;
    if ((ev_cnt - e0) !== 1 || bus.score !== 4'd1) begin
      errors++;
      $display("FAIL rst_repress_total: got ev=%0d score=%0d expected 1 1", ev_cnt - e0, bus.score);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.Rows        = 4'hF;
    bus.clear_score = 1'b0;
    set_keys(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    test_reset();
    test_hit();
    test_miss();
    test_held();
    test_invalid_mole();
    test_saturation();
    test_clear_on_hit();
    test_reset_mid_settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/whack_judge.md
WHACK_JUDGE -- requirements
Module: whack_judge

Interface
REQ-001 Parameter SCAN_WINDOW, default 400000, is the length in clk cycles of one full keypad scan period (4 ms at 100 MHz); it must be >= 4.
REQ-002 Parameter SCORE_W, default 8, is the score register width in bits.
REQ-003 Port clk, input, 1 bit: 100 MHz master clock; all state is updated on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous reset, active low.
REQ-005 Port Rows, input, 4 bits: raw keypad row lines (active low), shared with the scanner; asynchronous to clk.
REQ-006 Port decoded_row, input, 2 bits: last key row latched by the upstream keypad scanner.
REQ-007 Port decoded_col, input, 2 bits: last key column latched by the upstream keypad scanner.
REQ-008 Port mole_valid, input, 1 bit: a mole is currently displayed.
REQ-009 Port mole_row, input, 2 bits: grid row of the displayed mole.
REQ-010 Port mole_col, input, 2 bits: grid column of the displayed mole.
REQ-011 Port clear_score, input, 1 bit: synchronous clear of score and combo.
REQ-012 Port key_event, output, 1 bit: one-cycle pulse per accepted key press.
REQ-013 Port key_row, output, 2 bits: registered row of the last accepted press.
REQ-014 Port key_col, output, 2 bits: registered column of the last accepted press.
REQ-015 Port hit, output, 1 bit: one-cycle pulse when the press matches the mole.
REQ-016 Port miss, output, 1 bit: one-cycle pulse when the press does not match.
REQ-017 Port score, output, SCORE_W bits: running score, unsigned.
REQ-018 Port combo, output, 4 bits: consecutive-hit streak.

Function
REQ-019 Rows shall pass through a two-flop synchronizer; "activity" means the synchronized Rows != 4'b1111.
REQ-020 The FSM shall have states IDLE, SETTLE, JUDGE and HELD.
REQ-021 IDLE shall move to SETTLE on the first cycle of activity.
REQ-022 SETTLE shall count exactly SCAN_WINDOW cycles, ignoring activity, and then move to JUDGE, so that the upstream decoded_row/decoded_col are current.
REQ-023 JUDGE shall last one cycle, sample decoded_row, decoded_col, mole_valid, mole_row and mole_col, and move to HELD.
REQ-024 On the edge that leaves JUDGE: key_row/key_col load the decoded values; key_event pulses; exactly one of hit/miss pulses.
REQ-025 hit shall be asserted when mole_valid=1 and decoded_row==mole_row and decoded_col==mole_col; otherwise miss shall be asserted, including the case mole_valid=0.
REQ-026 Latency: if raw Rows is first sampled active at edge a, the pulses shall be high in the cycle after edge a+SCAN_WINDOW+3.
REQ-027 HELD shall keep a quiet counter that clears on any activity and increments otherwise; after SCAN_WINDOW consecutive quiet cycles the FSM returns to IDLE.
REQ-028 A key held any length of time shall yield exactly one key_event; no new event is accepted before release per REQ-027.
REQ-029 On a hit, score shall increment by 1 and saturate at 2^SCORE_W-1.
REQ-030 On a hit, combo shall increment by 1 and saturate at 15.
REQ-031 On a miss, combo shall clear to 0; score follows REQ-035.
REQ-032 When clear_score=1, score and combo shall be 0 on the next edge; clear_score overrides a simultaneous hit or miss, but the hit/miss and key_event pulses are still emitted.
REQ-033 key_event, hit and miss shall be 0 in all cycles other than those given in REQ-024.

Reset
REQ-034 While rst_n=0: state=IDLE; counters and synchronizer flops = 0/4'b1111; key_event=hit=miss=0; key_row=key_col=0; score=0; combo=0. Reset asserted mid-SETTLE or mid-HELD aborts with no pulse; after rst_n rises, a still-held key is treated as a new press.

Configuration
REQ-035 With macro WHACK_MISS_PENALTY_EN defined, a miss shall decrement score by 1, saturating at 0; without it, a miss shall leave score unchanged.

Verification (SCAN_WINDOW=16)
REQ-036 Mole (1,2) valid; decoded=(1,2); Rows=4'b1011 for 40 cycles, then 4'b1111 -> one key_event and hit; score 0->1; combo 0->1; key_row=1, key_col=2.
REQ-037 Mole (0,0) valid; decoded=(3,3); press -> one miss; combo->0; score unchanged without the macro, 5->4 with it, 0 stays 0 with it.
REQ-038 Rows held active for 500 cycles -> exactly one key_event; release, then quiet for fewer than 16 cycles, then press again -> no second event; quiet for 16 cycles, then press -> second event.
REQ-039 mole_valid=0, coordinates matching -> miss, not hit; 20 hits with SCORE_W=4 -> score 15, combo 15, no wrap.
REQ-040 clear_score asserted in the pulse cycle of a hit -> score=0 and combo=0; hit pulse is still observed.
REQ-041 rst_n driven low during SETTLE -> no pulse, all outputs 0; key still held after release of reset -> one event after SCAN_WINDOW+3 cycles.
